// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg: memory-map constants and DMA state encoding shared by the bus
// controller and the memoryunit decoder.
package gb_mem_pkg;
    typedef enum logic [1:0] {IDLE, START, RD, WR} dma_state_t;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN      = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [15:0] VRAM_LO      = 16'h8000;
    localparam logic [15:0] ERAM_LO      = 16'hA000;
    localparam logic [15:0] WRAM_LO      = 16'hC000;
    localparam logic [15:0] ECHO_LO      = 16'hE000;
    localparam logic [15:0] IO_LO        = 16'hFF00;
endpackage

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sole memoryunit bus master, arbitrating CPU accesses
// against the OAM DMA copy engine.
module oam_dma_controller
    import gb_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        dma_busy
);
    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    dma_state_t state, state_nx;
    logic [7:0] src_reg, idx, idx_nx, data_lat, src_eff;
    logic       reg_hit, reg_wr, dma_active, hram_acc, stall, busy_nx;

    assign reg_hit    = cpu_addr == DMA_REG_ADDR;
    assign reg_wr     = reg_hit & cpu_we;
    assign dma_active = state == RD || state == WR;
    assign hram_acc   = (cpu_oe | cpu_we) && cpu_addr >= HRAM_LO && cpu_addr <= HRAM_HI;
    assign stall      = dma_active & hram_acc;
    // echo pages E0-FF alias work RAM C0-DF
    assign src_eff    = src_reg >= 8'hE0 ? src_reg & 8'hDF : src_reg;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (reg_wr) begin
            state_nx = START;
            idx_nx   = '0;
        end else if (!stall) begin
            case (state)
                START:   begin state_nx = RD; idx_nx = '0; end
                RD:      state_nx = WR;
                WR:      begin state_nx = idx == LAST_IDX ? IDLE : RD; idx_nx = idx + 8'd1; end
                default: ;
            endcase
        end
        // a restart keeps busy asserted through its START cycle
        busy_nx   = state_nx == RD || state_nx == WR || (state_nx == START && dma_busy);
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_oe    = cpu_oe;
        mem_we    = cpu_we & ~reg_hit;
        cpu_rdata = reg_hit ? src_reg : mem_rdata;
        if (dma_active && !hram_acc) begin
            mem_addr  = state == RD ? {src_eff, idx} : OAM_BASE + {8'h00, idx};
            mem_wdata = data_lat;
            mem_oe    = state == RD;
            mem_we    = state == WR;
            cpu_rdata = reg_hit ? src_reg : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_reg  <= '0;
            idx      <= '0;
            data_lat <= '0;
            dma_busy <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            dma_busy <= busy_nx;
            if (reg_wr) src_reg <= cpu_wdata;
            if (state == RD && !stall) data_lat <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: drives random CPU traffic around OAM DMA transfers and
// compares bus behaviour and memory contents against a byte-level reference map.
module tb_oam_dma_controller;
    localparam logic [15:0] OAM = 16'hFE00;
    localparam logic [15:0] DMA = 16'hFF46;

    logic        clk = 0, rst = 1;
    logic [15:0] cpu_addr = 0;
    logic [7:0]  cpu_wdata = 0, cpu_rdata;
    logic        cpu_oe = 0, cpu_we = 0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_oe, mem_we, dma_busy;
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          vectors = 0, miscompares = 0;

    oam_dma_controller dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_oe(mem_oe), .mem_we(mem_we),
        .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] eff(input logic [7:0] s);
        return s >= 8'hE0 ? s - 8'h20 : s;
    endfunction

    function automatic logic [7:0] rand_page;
        return $urandom_range(0, 1) != 0 ? 8'($urandom_range(8'hC0, 8'hDF)) : 8'($urandom_range(8'hE0, 8'hFD));
    endfunction

    task automatic fill(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1; cpu_oe = 0;
        tick();
        cpu_we = 0;
        ref_mem[a] = d;
    endtask

    task automatic trigger(input logic [7:0] src);
        cpu_addr = DMA; cpu_wdata = src; cpu_we = 1; cpu_oe = 0;
        #1 chk("reg_wr_not_forwarded", mem_we, 0);
        tick();
        cpu_we = 0;
    endtask

    task automatic run_transfer(input logic [7:0] src, input bit allow_restart);
        int cycles, base, stalls, op;
        logic [7:0] cur, d;
        logic [15:0] a;
        bit restarted;
        cur = src; base = 0; stalls = 0; cycles = 0; restarted = 0;
        trigger(src);
        chk("start_not_busy", dma_busy, 0);
        tick();
        chk("busy_rise", dma_busy, 1);
        while (dma_busy && cycles < 2000) begin
            cpu_oe = 0; cpu_we = 0;
            op = (restarted && cycles == base - 1) ? 99 : $urandom_range(0, 15);
            case (op)
                0: begin
                    a = 16'($urandom_range(16'hFF80, 16'hFFFE)); d = 8'($urandom);
                    cpu_addr = a; cpu_wdata = d; cpu_we = 1; ref_mem[a] = d; stalls++;
                end
                1: begin
                    a = 16'($urandom_range(16'hFF80, 16'hFFFE));
                    cpu_addr = a; cpu_oe = 1; stalls++;
                    #2 chk("hram_read", cpu_rdata, ref_mem[a]);
                end
                2: begin
                    cpu_addr = 16'($urandom_range(16'h0000, 16'hFF45)); cpu_oe = 1;
                    #2 chk("blocked_read", cpu_rdata, 8'hFF);
                end
                3: begin
                    cpu_addr = 16'($urandom_range(16'hA000, 16'hA00F)); cpu_wdata = 8'($urandom); cpu_we = 1;
                end
                4: begin
                    cpu_addr = DMA; cpu_oe = 1;
                    #2 chk("dma_reg_read", cpu_rdata, cur);
                end
                5: begin
                    cpu_addr = 16'hFFFF; cpu_oe = 1;
                    #2 chk("ffff_blocked", cpu_rdata, 8'hFF);
                end
                6: if (allow_restart && !restarted && cycles > 20) begin
                    cur = rand_page();
                    cpu_addr = DMA; cpu_wdata = cur; cpu_we = 1;
                    restarted = 1; base = cycles + 2; stalls = 0;
                end
                default: ;
            endcase
            tick();
            cycles++;
        end
        cpu_oe = 0; cpu_we = 0;
        chk("busy_length", cycles, base + 320 + stalls);
        for (int i = 0; i < 160; i++) begin
            ref_mem[OAM + 16'(i)] = ref_mem[{eff(cur), 8'(i)}];
            chk("oam_byte", mem[OAM + 16'(i)], ref_mem[OAM + 16'(i)]);
        end
    endtask

    initial begin
        logic [7:0] src;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("reset_busy", dma_busy, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_oe", mem_oe, 0);
        cpu_addr = DMA; cpu_oe = 1;
        #1 chk("reset_src_reg", cpu_rdata, 8'h00);
        cpu_oe = 0;
        tick();

        cpu_addr = 16'hC010; cpu_wdata = 8'h5A; cpu_we = 1;
        #1 chk("pass_we", mem_we, 1);
        chk("pass_addr", mem_addr, 16'hC010);
        chk("pass_wdata", mem_wdata, 8'h5A);
        tick();
        cpu_we = 0; cpu_oe = 1;
        #1 chk("pass_rdata", cpu_rdata, 8'h5A);
        chk("pass_oe", mem_oe, 1);
        chk("pass_busy", dma_busy, 0);
        cpu_oe = 0;

        for (int a = 16'hC000; a <= 16'hDFFF; a++) fill(16'(a), 8'($urandom));
        for (int a = 16'hFF80; a <= 16'hFFFE; a++) fill(16'(a), 8'($urandom));
        for (int a = 16'hA000; a <= 16'hA00F; a++) fill(16'(a), 8'($urandom));

        run_transfer(8'hC0, 0);
        for (int t = 0; t < 6; t++) run_transfer(rand_page(), 1);

        for (int a = 16'hA000; a <= 16'hA00F; a++) chk("blocked_write_dropped", mem[a], ref_mem[a]);
        for (int a = 16'hFF80; a <= 16'hFFFE; a++) chk("hram_contents", mem[a], ref_mem[a]);

        src = rand_page();
        trigger(src);
        tick();
        chk("rst_test_busy", dma_busy, 1);
        repeat (160) tick();
        rst = 1;
        tick();
        chk("rst_abort_busy", dma_busy, 0);
        chk("rst_abort_we", mem_we, 0);
        rst = 0;
        tick();
        chk("rst_idle_we", mem_we, 0);
        for (int i = 0; i < 80; i++) ref_mem[OAM + 16'(i)] = ref_mem[{eff(src), 8'(i)}];
        for (int i = 0; i < 160; i++) chk("rst_oam_byte", mem[OAM + 16'(i)], ref_mem[OAM + 16'(i)]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
